// File: rtl/add_seq_pkg.sv
// Shared types and default widths for the adder sequencer.
package add_seq_pkg;
  localparam int ADDR_W_D = 6;
  localparam int DATA_W_D = 32;
  localparam int CNT_W_D  = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, OUT, DONE} state_t;

  typedef struct packed {
    logic [DATA_W_D-1:0] sum;
    logic                carry;
    logic [CNT_W_D-1:0]  index;
  } result_t;
endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that parks at zero; zero flags the end of a settle window.
module settle_timer #(
  parameter  int SETTLE_CYCLES = 4,
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  output logic          zero
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (en && cnt != '0)  cnt <= cnt - CW'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/add_sequencer.sv
// Steps the shared adder through operand pairs, waits out the carry chain, hands results out.
import add_seq_pkg::*;

module add_sequencer #(
  parameter int ADDR_W        = ADDR_W_D,
  parameter int DATA_W        = DATA_W_D,
  parameter int CNT_W         = CNT_W_D,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_pairs,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] adder_addr,
  input  logic [DATA_W-1:0] adder_sum,
  input  logic              adder_carry,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_sum,
  output logic              res_carry,
  output logic [CNT_W-1:0]  res_index
);
  localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int EW = ADDR_W + CNT_W + 1;

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("add_sequencer: SETTLE_CYCLES must be >= 1");
  end

  state_t           state;
  result_t          res;
  logic [CNT_W-1:0] idx, n_lat;
  logic [EW-1:0]    end_addr;
  logic             bad, hs, last, tmr_load, tmr_zero;

  // One past the last operand must not exceed the memory size; avoids a -1 for empty jobs.
  assign end_addr = EW'(base_addr) + EW'({num_pairs, 1'b0});
  assign bad      = base_addr[0] || (end_addr > (EW'(1) << ADDR_W));
  assign hs       = res_valid && res_ready;
  assign last     = (idx == n_lat - CNT_W'(1));
  assign tmr_load = (state == IDLE && start && !bad && num_pairs != '0) ||
                    (state == OUT && hs && !last);

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (state == SETTLE),
    .load_val (TW'(SETTLE_CYCLES - 1)),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      err        <= 1'b0;
      res_valid  <= 1'b0;
      res        <= '0;
      adder_addr <= '0;
      idx        <= '0;
      n_lat      <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (bad) err <= 1'b1;
          else if (num_pairs == '0) state <= DONE;
          else begin
            adder_addr <= base_addr;
            idx        <= '0;
            n_lat      <= num_pairs;
            state      <= SETTLE;
          end
        end
        SETTLE: if (tmr_zero) begin
          res       <= '{sum: adder_sum, carry: adder_carry, index: idx};
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (hs) begin
          res_valid <= 1'b0;
          if (last) state <= DONE;
          else begin
            idx        <= idx + CNT_W'(1);
            adder_addr <= adder_addr + ADDR_W'(2);
            state      <= SETTLE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign res_sum   = res.sum;
  assign res_carry = res.carry;
  assign res_index = res.index;
endmodule

// File: doc/add_sequencer.md
# add_sequencer

Sequencer for the shared 32-bit ripple-carry adder and its operand memory. On a start command it steps the adder's 6-bit operand address through a run of operand pairs. For each pair it waits a fixed settle time, sized to the adder's worst-case 32-bit carry chain, then registers the sum and carry. Each result is presented to the consumer over a valid/ready handshake. It sits between the adder/operand-memory datapath and whatever control logic issues add jobs.

## Interface
- ADDR_W, 6, operand memory address width (matches adder address input)
- DATA_W, 32, sum width
- CNT_W, 4, width of pair count and result index
- SETTLE_CYCLES, 4, clock cycles the adder output must be stable before capture; must be ≥1, elaboration error otherwise

- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  job request; sampled only in IDLE
- base_addr  in  ADDR_W  address of first operand of first pair; must be even
- num_pairs  in  CNT_W  number of pairs in job
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  one-cycle pulse when a start is rejected
- adder_addr  out  ADDR_W  registered address driven to the adder/operand memory
- adder_sum  in  DATA_W  adder sum output
- adder_carry  in  1  adder carry-out
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_sum  out  DATA_W  registered sum
- res_carry  out  1  registered carry
- res_index  out  CNT_W  pair index of the current result, 0-based

## Operation
- States: IDLE, SETTLE, OUT, DONE.
- IDLE, start=1, checks run in this order:
  - base_addr odd, or base_addr + 2*num_pairs − 1 > 2^ADDR_W − 1: err pulses, state stays IDLE, nothing else changes.
  - num_pairs=0: go to DONE.
  - Otherwise: adder_addr←base_addr, idx←0, settle counter←SETTLE_CYCLES−1, go to SETTLE. Latch num_pairs internally.
- SETTLE: counter decrements each cycle. On the edge where counter=0: res_sum←adder_sum, res_carry←adder_carry, res_index←idx, res_valid←1, go to OUT.
- OUT: res_valid held with res_sum, res_carry and res_index stable until res_valid & res_ready at an edge.
  - On that handshake with idx = latched num_pairs−1: res_valid←0, go to DONE.
  - On that handshake otherwise: res_valid←0, idx←idx+1, adder_addr←adder_addr+2, counter←SETTLE_CYCLES−1, go to SETTLE.
- DONE: done=1 for exactly one cycle, then IDLE. adder_addr keeps its last value.
- adder_addr changes only on entry to SETTLE. It is stable for the full settle window and the whole OUT state.
- start outside IDLE is ignored; the job is not queued.
- res_ready while res_valid=0 is ignored.
- base_addr and num_pairs are only sampled at the accepted start.
- Address arithmetic is unsigned ADDR_W-bit. The range check guarantees no wrap.

## Timing
- Reset (async assert): state IDLE. busy, done, err, res_valid and res_carry are 0. adder_addr, res_sum, res_index and the counter are 0.
- Reset deassertion takes effect at the next rising edge.
- Reset mid-job abandons the job: no done pulse, and the pending result is dropped.
- Start accepted at edge E: busy and the new adder_addr are visible after E. res_valid rises after edge E+SETTLE_CYCLES.
- Handshake at edge H, more pairs remaining: res_valid falls after H. The next res_valid rises after edge H+SETTLE_CYCLES.
- Final handshake at edge H: done is high during cycle H+1, and busy falls after edge H+1.
- Throughput with res_ready tied high: one result per SETTLE_CYCLES+1 cycles.
- Rejected start at edge E: err is high during cycle E+1 only, and busy stays 0.
- num_pairs=0 start at edge E: done is high during cycle E+1, with no res_valid.

## Structure
- Package add_seq_pkg holds:
  - the state enum (IDLE, SETTLE, OUT, DONE);
  - default ADDR_W, DATA_W and CNT_W constants;
  - a result struct {sum, carry, index}.
- Sub-module settle_timer: loadable down-counter with a load input, a load value and a zero flag, parameterised on SETTLE_CYCLES. It is instantiated once.
- All remaining logic is a single FSM plus output registers in add_sequencer.

## Test plan
- base_addr=0, num_pairs=1, operands 0x00000001 + 0xFFFFFFFF, res_ready=1 -> res_valid 4 cycles after start with res_sum=0x00000000, res_carry=1, res_index=0; done one cycle after the handshake.
- base_addr=0, num_pairs=5, res_ready=1 -> adder_addr sequence 0,2,4,6,8; five results with indices 0–4, 5 cycles apart; a single done pulse.
- Same job as the previous scenario with res_ready held low for 10 cycles on result 2 -> res_sum and adder_addr stay stable and no further address advance happens; the job resumes normally on ready.
- start with base_addr=63 (odd), and separately base_addr=62 with num_pairs=2 (overflow) -> err pulse, busy stays 0, adder_addr unchanged. A second start during an active job is ignored.
- rst_n asserted during SETTLE of pair 2 -> all outputs 0 immediately with no done. A new start after release runs from pair 0 correctly.
- num_pairs=0 -> done in the cycle after start, and res_valid never asserts.
